// File: rtl/deser_pkg.sv
// Shared definitions for the serial deserialiser: FSM state encoding,
// default counter/word widths and the even-parity helper.
// Optional feature macro: DESER_PARITY_EN (adds the PARITY state).
package deser_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LOAD   = ST_LOAD,
    S_SHIFT  = ST_SHIFT,
    S_PARITY = ST_PARITY,
    S_HOLD   = ST_HOLD
  } state_t;

  // Even parity: the data reduction XOR combined with the received parity
  // bit must be 0, so a 1 here flags an error.
  function automatic logic evenParityErr(input logic dataXor, input logic parityBit);
    return dataXor ^ parityBit;
  endfunction

endpackage

// File: rtl/deser_shreg.sv
// W-bit shift-in register: bits enter at the LSB and move toward the MSB,
// so an MSB-first serial stream lands in natural bit order.
module deser_shreg
  import deser_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_shift,
  input  logic         i_din,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Shift one bit in whenever the controller accepts a serial bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_din};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_deser_ctrl.sv
// Bit-serial to parallel deserialiser controller. Drives an external bit
// counter (load/enable) and uses its count to find word boundaries, then
// presents each word on a valid/ready handshake.
// Optional feature macro: DESER_PARITY_EN (trailing even-parity bit check).
module serial_deser_ctrl
  import deser_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         din_valid,
  input  logic         din,
  input  logic [N-1:0] count_in,
  output logic         cnt_load,
  output logic         cnt_enable,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         parity_err
);

  localparam logic [N-1:0] LAST_COUNT = N'(W - 1);

  state_t       r_state;
  state_t       w_next;
  logic         w_shift_en;
  logic         w_last_bit;
  logic [W-1:0] w_shreg;
  logic [W-1:0] w_shreg_next;
  logic [W-1:0] r_dout;
  logic         r_dout_valid;
`ifdef DESER_PARITY_EN
  logic         w_parity_bit;
  logic         r_parity_err;
`endif

  deser_shreg #(.W(W)) u_shreg (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_shift (w_shift_en),
    .i_din   (din),
    .o_q     (w_shreg)
  );

  assign w_shreg_next = {w_shreg[W-2:0], din};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and counter-control decode; an out-of-range count is treated
  // as the terminal bit so a misbehaving counter cannot strand the FSM.
  always_comb begin
    w_next       = r_state;
    cnt_load     = 1'b0;
    cnt_enable   = 1'b0;
    busy         = (r_state != S_IDLE);
    w_shift_en   = 1'b0;
    w_last_bit   = 1'b0;
`ifdef DESER_PARITY_EN
    w_parity_bit = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        cnt_load = 1'b1;
        w_next   = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_enable = din_valid;
        w_shift_en = din_valid;
        if (din_valid && (count_in >= LAST_COUNT)) begin
          w_last_bit = 1'b1;
`ifdef DESER_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_HOLD;
`endif
        end
      end
`ifdef DESER_PARITY_EN
      S_PARITY: begin
        cnt_enable = din_valid;
        if (din_valid) begin
          w_parity_bit = 1'b1;
          w_next       = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (dout_ready) w_next = start ? S_LOAD : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output word capture and valid flag; dout keeps its value after handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_last_bit) begin
        r_dout <= w_shreg_next;
`ifndef DESER_PARITY_EN
        r_dout_valid <= 1'b1;
`endif
      end
`ifdef DESER_PARITY_EN
      if (w_parity_bit) r_dout_valid <= 1'b1;
`endif
      if ((r_state == S_HOLD) && dout_ready) r_dout_valid <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  // Parity result lives alongside the word and is cleared as the next word loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity_err <= 1'b0;
    end else if (w_parity_bit) begin
      r_parity_err <= evenParityErr(^r_dout, din);
    end else if (r_state == S_LOAD) begin
      r_parity_err <= 1'b0;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_serial_deser_ctrl.sv
// Self-checking bench for serial_deser_ctrl. A simple bit counter stands in
// for the real one; the reference model is "the last W bits accepted since
// reset", packed arithmetically. Works with or without DESER_PARITY_EN.
module tb_serial_deser_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         din_valid = 1'b0;
  logic         din = 1'b0;
  logic         dout_ready = 1'b0;
  logic [N-1:0] count_in;
  logic [N-1:0] tbCount;
  logic [N-1:0] ovrCount = '0;
  logic         ovrEn = 1'b0;
  logic         cnt_load;
  logic         cnt_enable;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         busy;
  logic         parity_err;

  int           testsRun = 0;
  int           testsFailed = 0;
  logic [W-1:0] history = '0;

  serial_deser_ctrl #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .din_valid  (din_valid),
    .din        (din),
    .count_in   (count_in),
    .cnt_load   (cnt_load),
    .cnt_enable (cnt_enable),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .parity_err (parity_err)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Stand-in for the external bit counter, with an override for forcing
  // out-of-range counts.
  always @(posedge clk or negedge reset) begin
    if (!reset) tbCount <= '0;
    else if (cnt_load) tbCount <= '0;
    else if (cnt_enable) tbCount <= tbCount + 1'b1;
  end

  assign count_in = ovrEn ? ovrCount : tbCount;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Start a word (or continue one already in LOAD) and check the load pulse.
  task automatic beginWord(input bit inLoad);
    if (!inLoad) begin
      start = 1'b1;
      din_valid = 1'($urandom % 2);
      din = 1'($urandom % 2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    din_valid = 1'b0;
    #1;
    checkOutput("loadPulse", cnt_load, 1);
    checkOutput("loadBusy", busy, 1);
    checkOutput("loadEnable", cnt_enable, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("loadOnce", cnt_load, 0);
    checkOutput("countCleared", tbCount, 0);
  endtask

  // Deliver one valid bit, optionally preceded by a few stall cycles.
  task automatic shiftBit(input bit b, input int gapPct, input int maxGaps, input bit toHistory);
    int gaps;
    gaps = 0;
    while (gaps < maxGaps && ($urandom % 100) < gapPct) begin
      din_valid = 1'b0;
      din = 1'($urandom % 2);
      #1;
      checkOutput("stallEnable", cnt_enable, 0);
      checkOutput("stallValid", dout_valid, 0);
      @(posedge clk);
      @(negedge clk);
      gaps++;
    end
    din_valid = 1'b1;
    din = b;
    #1;
    checkOutput("bitEnable", cnt_enable, 1);
    checkOutput("bitLoad", cnt_load, 0);
    @(posedge clk);
    if (toHistory) history = {history[W-2:0], b};
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Send a full word MSB first.
  task automatic sendWord(input logic [W-1:0] value, input int gapPct, input int maxGaps);
    for (int i = W - 1; i >= 0; i--) begin
      if (i == W - 1) checkOutput("parityCleared", parity_err, 0);
      if (i == 0) checkOutput("countBeforeLast", count_in, W - 1);
      checkOutput("midValid", dout_valid, 0);
      checkOutput("midBusy", busy, 1);
      shiftBit(value[i], gapPct, maxGaps, 1'b1);
    end
  endtask

  // Complete the word (parity bit when enabled) and check the presented word.
  task automatic finishWord(input bit p);
`ifdef DESER_PARITY_EN
    checkOutput("preParityValid", dout_valid, 0);
    shiftBit(p, 30, 1, 1'b0);
    checkOutput("parityErr", parity_err, 32'((^history) ^ p));
`else
    checkOutput("parityTied", parity_err, 32'(p & 1'b0));
`endif
    checkOutput("wordValid", dout_valid, 1);
    checkOutput("wordData", dout, history);
    checkOutput("holdBusy", busy, 1);
  endtask

  // Stall the consumer, then accept, optionally requesting the next word.
  task automatic holdAndRelease(input int waitCycles, input bit nextStart);
    for (int c = 0; c < waitCycles; c++) begin
      dout_ready = 1'b0;
      din_valid = 1'($urandom % 2);
      din = 1'($urandom % 2);
      start = 1'($urandom % 2);
      #1;
      checkOutput("holdData", dout, history);
      checkOutput("holdValid", dout_valid, 1);
      checkOutput("holdEnable", cnt_enable, 0);
      @(posedge clk);
      @(negedge clk);
    end
    dout_ready = 1'b1;
    start = nextStart;
    din_valid = 1'($urandom % 2);
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
    start = 1'b0;
    din_valid = 1'b0;
    #1;
    checkOutput("releaseValid", dout_valid, 0);
    checkOutput("releaseData", dout, history);
    if (!nextStart) begin
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleLoad", cnt_load, 0);
    end
  endtask

  // Main sequence: directed scenarios followed by randomized words.
  initial begin
    bit inLoad;
    bit nextStart;
    logic [W-1:0] value;

    #2;
    checkOutput("rstDout", dout, 0);
    checkOutput("rstValid", dout_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLoad", cnt_load, 0);
    checkOutput("rstEnable", cnt_enable, 0);
    checkOutput("rstParity", parity_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idleAfterReset", busy, 0);

    beginWord(1'b0);
    sendWord(8'hA5, 0, 0);
    finishWord(1'b0);
    holdAndRelease(1, 1'b0);

    beginWord(1'b0);
    sendWord(8'h3C, 100, 1);
    finishWord(1'b1);
    holdAndRelease(5, 1'b1);
    beginWord(1'b1);
    sendWord(8'hA5, 0, 0);
    finishWord(1'b1);
    holdAndRelease(2, 1'b0);

    beginWord(1'b0);
    for (int i = 0; i < 3; i++) shiftBit(1'($urandom % 2), 0, 0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    history = '0;
    checkOutput("midRstValid", dout_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDout", dout, 0);
    checkOutput("midRstEnable", cnt_enable, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midRstIdle", busy, 0);
    beginWord(1'b0);
    sendWord(8'h81, 20, 2);
    finishWord(1'b0);
    holdAndRelease(0, 1'b0);

    beginWord(1'b0);
    shiftBit(1'($urandom % 2), 0, 0, 1'b1);
    shiftBit(1'($urandom % 2), 0, 0, 1'b1);
    ovrCount = 4'd12;
    ovrEn = 1'b1;
    shiftBit(1'($urandom % 2), 0, 0, 1'b1);
    ovrEn = 1'b0;
    finishWord(1'($urandom % 2));
    holdAndRelease(1, 1'b0);

    inLoad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      value = W'($urandom);
      nextStart = 1'($urandom % 2);
      beginWord(inLoad);
      sendWord(value, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)));
      finishWord(1'($urandom % 2));
      holdAndRelease(int'($urandom_range(0, 3)), nextStart);
      inLoad = nextStart;
    end
    if (inLoad) begin
      beginWord(1'b1);
      sendWord(8'h5A, 0, 0);
      finishWord(1'b0);
      holdAndRelease(0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/serial_deser_ctrl.md
Name: serial_deser_ctrl

Overview:
Bit-serial to parallel deserialiser that sits directly downstream of the shared N-bit bit counter.
- Drives the counter's Load and enable inputs and consumes its count output to find word boundaries.
- Presents each assembled W-bit word on a valid/ready output handshake.

Parameters:
N, 4, width of the counter's count bus (count_in).
W, 8, deserialised word width; legal range 2 to 2^N.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request to begin a new word; sampled in IDLE and in HOLD only.
din_valid  input  1  serial bit qualifier.
din  input  1  serial data bit, MSB first.
count_in  input  N  counter output = number of bits already accepted in current word.
cnt_load  output  1  clears counter to 0 (one-cycle pulse).
cnt_enable  output  1  counter increment enable.
dout  output  W  assembled word.
dout_valid  output  1  dout holds a complete word.
dout_ready  input  1  consumer accepts dout.
busy  output  1  high in any state other than IDLE.
parity_err  output  1  parity check result; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register=0; dout=0.
  - dout_valid=0, parity_err=0, busy=0, cnt_load=0, cnt_enable=0.
  - A partial word is discarded.
- States: IDLE, LOAD, SHIFT, [PARITY], HOLD. cnt_load, cnt_enable and busy are combinational decodes of state and inputs.
- IDLE: start=1 -> LOAD. din and din_valid are ignored.
- LOAD: cnt_load=1 for exactly one cycle; the counter reads 0 on the next cycle. Unconditionally -> SHIFT.
- SHIFT:
  - cnt_enable=din_valid.
  - On din_valid=1: shreg <= {shreg[W-2:0], din}.
  - When din_valid=1 and count_in==W-1: dout <= {shreg[W-2:0], din}, dout_valid <= 1, go to HOLD (or to PARITY when the feature is enabled).
  - din_valid=0 stalls indefinitely with no state change.
  - count_in > W-1 in SHIFT is a protocol violation: treat as the terminal bit (same action as count_in==W-1) so the FSM cannot hang.
- HOLD:
  - dout and dout_valid are stable; din_valid is ignored; cnt_enable=0.
  - dout_ready=1 -> dout_valid <= 0. If start=1 in the same cycle go to LOAD (back-to-back words), else go to IDLE.
  - dout_ready=0: remain in HOLD, no change.
- start outside IDLE/HOLD is ignored.
- Latency: dout_valid rises on the clock edge that samples the W-th valid bit (feature off). Minimum word period is W+2 cycles from start to dout_valid.
- dout keeps its last value after the handshake until the next word completes.

Optional Feature:
Macro DESER_PARITY_EN.
- Defined:
  - After the W-th bit the FSM goes to PARITY instead of setting dout_valid.
  - In PARITY, cnt_enable=din_valid. The next valid bit is the even-parity bit.
  - On that bit: parity_err <= (^dout) ^ din, dout_valid <= 1, go to HOLD.
  - parity_err is held alongside dout_valid and cleared when the next word starts (LOAD).
- Undefined: no PARITY state; parity_err is tied to 0.

Decomposition:
- Package deser_pkg:
  - state encoding localparams (IDLE=0, LOAD=1, SHIFT=2, PARITY=3, HOLD=4, 3-bit state).
  - default N and W.
  - function for even-parity reduction.
- One natural sub-module: deser_shreg (W-bit shift-in register with shift enable and async active-low clear). The FSM stays in serial_deser_ctrl.
- The counter is instantiated beside this block at the next level up, not inside it.

Test Plan:
1. reset=0 mid-simulation -> all outputs 0 immediately (asynchronous); release -> IDLE, busy=0.
2. start pulse, then 0xA5 MSB-first with din_valid held high -> cnt_load high exactly 1 cycle, then cnt_enable high for 8 cycles; dout=0xA5 with dout_valid on the 8th bit edge; busy=1 throughout.
3. 0x3C with din_valid high every other cycle -> cnt_enable mirrors din_valid; dout=0x3C; count_in reaches 7 before completion.
4. dout_ready low for 5 cycles in HOLD with random din and din_valid -> dout=0x3C stable and dout_valid held; then dout_ready=1 and start=1 together -> LOAD next cycle, dout_valid=0.
5. reset asserted after 3 bits of a word -> IDLE, dout_valid=0; a new start with 0x81 -> dout=0x81 with no leftover bits.
6. DESER_PARITY_EN defined: 0xA5 then parity bit 0 -> parity_err=0; 0xA5 then parity bit 1 -> parity_err=1 with dout_valid; next start clears parity_err.
